// File: rtl/req_frontend_if.sv
// Bus bundle for the request front-end: raw keys, arbiter grants and the
// overflow clear go in; request levels, pending counts and overflow come out.
interface req_frontend_if #(
  parameter int CNT_W = 3
);
  // Raw push-button inputs (asynchronous to clk)
  logic             key_a;
  logic             key_b;
  logic             key_c;
  // One-cycle grant pulses from the arbiter
  logic             trg_a;
  logic             trg_b;
  logic             trg_c;
  // Clears all sticky overflow flags
  logic             ovf_clr;
  // Request levels towards the arbiter
  logic             a;
  logic             b;
  logic             c;
  // Pending request counts
  logic [CNT_W-1:0] pend_a;
  logic [CNT_W-1:0] pend_b;
  logic [CNT_W-1:0] pend_c;
  // Sticky overflow flags, [2]=c [1]=b [0]=a
  logic [2:0]       ovf;

  // Driver side (arbiter plus buttons)
  modport master (
    output key_a, key_b, key_c,
    output trg_a, trg_b, trg_c,
    output ovf_clr,
    input  a, b, c,
    input  pend_a, pend_b, pend_c,
    input  ovf
  );

  // Front-end side
  modport slave (
    input  key_a, key_b, key_c,
    input  trg_a, trg_b, trg_c,
    input  ovf_clr,
    output a, b, c,
    output pend_a, pend_b, pend_c,
    output ovf
  );
endinterface

// File: rtl/req_frontend.sv
// Request front-end: per channel a 2-flop synchroniser, a debouncer with a
// press detector, and a saturating pending counter that is retired by
// arbiter grants. Request levels are decoded straight from the counters.
module req_frontend #(
  parameter int DEB_CYCLES     = 50000,
  parameter int CNT_W          = 3,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  req_frontend_if.slave  bus
);

  localparam int NCH = 3;
  localparam int DW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  // Channel vectors, index 0=a 1=b 2=c
  logic [NCH-1:0]            key_raw;
  logic [NCH-1:0]            trg_v;
  logic [NCH-1:0]            req_v;
  logic [NCH-1:0]            ovf_v;
  logic [NCH-1:0][CNT_W-1:0] pend_v;

  assign key_raw = {bus.key_c, bus.key_b, bus.key_a};
  assign trg_v   = {bus.trg_c, bus.trg_b, bus.trg_a};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic          key_norm;
      logic          s1_q;
      logic          s2_q;
      logic          stable_q;
      logic          stable_d;
      logic [DW-1:0] dcnt_q;
      logic [DW-1:0] dcnt_d;
      logic          evt;
      logic [CNT_W-1:0] pend_q;
      logic [CNT_W-1:0] pend_d;
      logic          ovf_q;
      logic          ovf_d;
      logic          ovf_set;

      // Normalise polarity before synchronising so everything inside is 1 = pressed
      assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw[gi] : key_raw[gi];

      // Two-flop synchroniser for the asynchronous button input
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= key_norm;
          s2_q <= s1_q;
        end
      end

      // Debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples
      always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        evt      = 1'b0;
        if (s2_q == stable_q) begin
          dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
          stable_d = s2_q;
          dcnt_d   = '0;
          // Only the released-to-pressed acceptance counts as a press
          evt      = s2_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      // Debouncer state registers
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stable_q <= 1'b0;
          dcnt_q   <= '0;
        end else begin
          stable_q <= stable_d;
          dcnt_q   <= dcnt_d;
        end
      end

      // Pending counter: a press and a grant in the same cycle cancel out
      always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (evt && !trg_v[gi]) begin
          if (pend_q == PEND_MAX) begin
            ovf_set = 1'b1;
          end else begin
            pend_d = pend_q + PEND_ONE;
          end
        end else if (!evt && trg_v[gi]) begin
          // A grant with nothing pending is a stray and is ignored
          if (pend_q != '0) begin
            pend_d = pend_q - PEND_ONE;
          end
        end
        // A new overflow outranks a simultaneous clear
        if (ovf_set) begin
          ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
          ovf_d = 1'b0;
        end else begin
          ovf_d = ovf_q;
        end
      end

      // Pending count and sticky overflow registers
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pend_q <= '0;
          ovf_q  <= 1'b0;
        end else begin
          pend_q <= pend_d;
          ovf_q  <= ovf_d;
        end
      end

      assign pend_v[gi] = pend_q;
      assign ovf_v[gi]  = ovf_q;
      // Request is a pure decode of the registered count, no extra stage
      assign req_v[gi]  = (pend_q != '0);
    end
  endgenerate

  assign bus.a      = req_v[0];
  assign bus.b      = req_v[1];
  assign bus.c      = req_v[2];
  assign bus.pend_a = pend_v[0];
  assign bus.pend_b = pend_v[1];
  assign bus.pend_c = pend_v[2];
  assign bus.ovf    = ovf_v;

endmodule

// File: tb/tb_req_frontend.sv
// Bench for req_frontend: directed scenarios followed by random key/grant
// traffic, with a cycle-level reference model checked on every falling edge.
module tb_req_frontend;

  localparam int DEB  = 4;
  localparam int W    = 2;
  localparam int PMAX = (1 << W) - 1;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  bit   chk_en;

  req_frontend_if #(.CNT_W(W)) bus ();

  req_frontend #(
    .DEB_CYCLES     (DEB),
    .CNT_W          (W),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel keeps the last DEB synchronised samples; the accepted level
  // flips when all of them disagree with it. Pending is a plain integer.
  bit [2:0]     m_s1, m_s2, m_stable;
  bit [DEB-1:0] m_hist [3];
  int           m_pend [3];
  bit [2:0]     m_ovf;

  always @(posedge clk or negedge rst) begin
    bit [2:0] keys;
    bit [2:0] trgs;
    bit       all_diff;
    bit       evt;
    bit       set;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_ovf = '0;
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = '0;
        m_pend[i] = 0;
      end
    end else begin
      keys = ~{bus.key_c, bus.key_b, bus.key_a};
      trgs = {bus.trg_c, bus.trg_b, bus.trg_a};
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
        all_diff  = m_stable[i] ? (m_hist[i] == '0) : (&m_hist[i]);
        evt = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          evt = m_stable[i];
        end
        set = 1'b0;
        if (evt && !trgs[i]) begin
          if (m_pend[i] < PMAX) m_pend[i]++;
          else set = 1'b1;
        end else if (!evt && trgs[i] && m_pend[i] > 0) begin
          m_pend[i]--;
        end
        if (set) m_ovf[i] = 1'b1;
        else if (bus.ovf_clr) m_ovf[i] = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = keys;
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pend_a", int'(bus.pend_a), m_pend[0]);
      chk("pend_b", int'(bus.pend_b), m_pend[1]);
      chk("pend_c", int'(bus.pend_c), m_pend[2]);
      chk("req_a", int'(bus.a), int'(m_pend[0] != 0));
      chk("req_b", int'(bus.b), int'(m_pend[1] != 0));
      chk("req_c", int'(bus.c), int'(m_pend[2] != 0));
      chk("ovf", int'(bus.ovf), int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int ch, input logic v);
    case (ch)
      0: bus.key_a = v;
      1: bus.key_b = v;
      default: bus.key_c = v;
    endcase
  endtask

  task automatic set_trg(input int ch, input logic v);
    case (ch)
      0: bus.trg_a = v;
      1: bus.trg_b = v;
      default: bus.trg_c = v;
    endcase
  endtask

  // A clean press and release, each held well beyond the debounce window
  task automatic press(input int ch);
    set_key(ch, 1'b0);
    step(8);
    set_key(ch, 1'b1);
    step(8);
  endtask

  int hold [3];

  initial begin
    n_total = 0;
    n_bad   = 0;
    chk_en  = 1'b0;
    rst     = 1'b0;
    bus.key_a = 1'b1; bus.key_b = 1'b1; bus.key_c = 1'b1;
    bus.trg_a = 1'b0; bus.trg_b = 1'b0; bus.trg_c = 1'b0;
    bus.ovf_clr = 1'b0;

    step(3);
    chk_en = 1'b1;
    chk("rst_pend_a", int'(bus.pend_a), 0);
    chk("rst_req_a", int'(bus.a), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst = 1'b1;

    // Basic press: count appears on the 6th edge after the key goes down
    bus.key_a = 1'b0;
    step(5);
    chk("basic_pend_a_e5", int'(bus.pend_a), 0);
    step(1);
    chk("basic_pend_a_e6", int'(bus.pend_a), 1);
    chk("basic_req_a", int'(bus.a), 1);
    bus.trg_a = 1'b1;
    step(1);
    bus.trg_a = 1'b0;
    chk("grant_pend_a", int'(bus.pend_a), 0);
    chk("grant_req_a", int'(bus.a), 0);
    bus.key_a = 1'b1;
    step(8);

    // Glitch reject on b, then a real press
    bus.key_b = 1'b0;
    step(3);
    bus.key_b = 1'b1;
    step(10);
    chk("glitch_pend_b", int'(bus.pend_b), 0);
    press(1);
    chk("press_pend_b", int'(bus.pend_b), 1);
    bus.trg_b = 1'b1;
    step(1);
    bus.trg_b = 1'b0;

    // Saturation on c
    for (int i = 0; i < 4; i++) press(2);
    chk("sat_pend_c", int'(bus.pend_c), 3);
    chk("sat_ovf", int'(bus.ovf), 4);
    bus.key_c = 1'b0;
    step(5);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("set_wins_ovf", int'(bus.ovf), 4);
    bus.key_c = 1'b1;
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("clr_ovf", int'(bus.ovf), 0);
    step(7);
    bus.trg_c = 1'b1;
    step(3);
    bus.trg_c = 1'b0;
    chk("drain_pend_c", int'(bus.pend_c), 0);

    // Press event coinciding with a grant
    press(0);
    chk("pre_sim_pend_a", int'(bus.pend_a), 1);
    bus.key_a = 1'b0;
    step(5);
    bus.trg_a = 1'b1;
    step(1);
    bus.trg_a = 1'b0;
    chk("evt_trg_pend_a", int'(bus.pend_a), 1);
    bus.key_a = 1'b1;
    bus.trg_b = 1'b1;
    step(1);
    bus.trg_b = 1'b0;
    chk("stray_pend_b", int'(bus.pend_b), 0);
    step(7);

    // Reset in the middle of operation
    press(0);
    chk("pre_rst_pend_a", int'(bus.pend_a), 2);
    bus.key_b = 1'b0;
    step(4);
    #2;
    rst = 1'b0;
    #1;
    chk("async_pend_a", int'(bus.pend_a), 0);
    chk("async_req_a", int'(bus.a), 0);
    chk("async_pend_b", int'(bus.pend_b), 0);
    chk("async_pend_c", int'(bus.pend_c), 0);
    #2;
    rst = 1'b1;
    step(5);
    chk("post_rst_pend_b_e5", int'(bus.pend_b), 0);
    step(1);
    chk("post_rst_pend_b_e6", int'(bus.pend_b), 1);
    bus.key_b = 1'b1;
    step(8);

    // Random traffic against the model
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          case (i)
            0: bus.key_a = ~bus.key_a;
            1: bus.key_b = ~bus.key_b;
            default: bus.key_c = ~bus.key_c;
          endcase
          hold[i] = $urandom_range(1, 12);
        end else begin
          hold[i]--;
        end
        set_trg(i, ($urandom_range(0, 7) == 0));
      end
      bus.ovf_clr = ($urandom_range(0, 31) == 0);
      step(1);
    end
    bus.trg_a = 1'b0; bus.trg_b = 1'b0; bus.trg_c = 1'b0;
    bus.ovf_clr = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/req_frontend.md
# req_frontend

Request front-end for the round-robin arbiter. It conditions three raw push-button inputs with a synchroniser, a debouncer and press detection. Each press is queued in a per-channel saturating pending counter. The block presents a level request `a`/`b`/`c` while work is pending, and retires one pending request per arbiter grant pulse `trg_a`/`trg_b`/`trg_c`.

## Interface
- `DEB_CYCLES`, 50000: consecutive stable cycles needed to accept a key change (1 ms at 50 MHz); minimum 2.
- `CNT_W`, 3: pending counter width; max pending per channel = 2^CNT_W − 1.
- `KEY_ACTIVE_LOW`, 1: 1 means key pressed = input 0; 0 means pressed = input 1.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `key_a`/`key_b`/`key_c`, in, 1 each: raw asynchronous button inputs.
- `trg_a`/`trg_b`/`trg_c`, in, 1 each: grant pulses from the arbiter; one pulse consumes one pending request.
- `ovf_clr`, in, 1: synchronous clear of all overflow flags.
- `a`/`b`/`c`, out, 1 each: request level; high iff that channel's pending count is nonzero.
- `pend_a`/`pend_b`/`pend_c`, out, CNT_W each: pending counts.
- `ovf`, out, 3: sticky overflow flags [2]=c, [1]=b, [0]=a.

## Operation
- Per channel, the pipeline is: 2-flop synchroniser (`s1` → `s2`), then debouncer, then press event, then pending counter.
- Polarity is normalised at the synchroniser input, so all internal signals use 1 = pressed.
- Debouncer holds `stable` (the accepted level) and a counter `dcnt` of width clog2(DEB_CYCLES):
  - If `s2` == `stable`: `dcnt` <= 0.
  - If `s2` != `stable` and `dcnt` < DEB_CYCLES−1: `dcnt` increments.
  - If `s2` != `stable` and `dcnt` == DEB_CYCLES−1: `stable` <= `s2` and `dcnt` <= 0.
- A glitch shorter than DEB_CYCLES cycles restarts the count; `stable` does not change.
- Press event `evt` is combinational. It is high in the cycle in which `stable` transitions from 0 to 1. Releases are debounced too but generate no event.
- Pending counter update at each clock edge, per channel:
  - `evt` & !`trg`: increment if below max. At max, hold the count and set `ovf[x]` (the press is dropped).
  - !`evt` & `trg`: decrement if nonzero. If zero, hold at 0 (stray grant ignored, no underflow, no flag).
  - `evt` & `trg`: count unchanged, also at max and at 0. `ovf` is not set.
  - Neither: hold.
- `a`/`b`/`c` = (`pend_x` != 0), decoded directly from the registered count. No extra pipeline stage.
- `ovf[x]` is sticky until `ovf_clr`. If a set and `ovf_clr` occur in the same cycle, the set wins.
- Channels are fully independent. Simultaneous events on several channels are all counted.

## Timing
- Reset (`rst` = 0), asynchronous: `s1`/`s2`/`stable` = released, `dcnt` = 0, all `pend` = 0, `ovf` = 0, `a`/`b`/`c` = 0. Outputs drop immediately and queued presses are lost.
- On reset release, the first edge samples keys normally. No event is generated for a key that was already held during reset until `stable` is accepted after debounce.
- Latency from the first edge that samples a pressed key (edge 1) to `pend` increment is edge 2+DEB_CYCLES. `a` rises in the same cycle.
- Grant latency: when `trg_x` is high at edge N, `pend_x` is decremented at edge N. `a` falls after edge N if the count reaches 0.
- Throughput: at most one event per channel per press/release pair. Minimum press period is 2·DEB_CYCLES cycles.

## Test plan
- Bench uses DEB_CYCLES=4, CNT_W=2, KEY_ACTIVE_LOW=1.
- Basic press: after reset, drive `key_a`=0 and hold it. Expect `pend_a`=1 and `a`=1 after the 6th edge. Pulse `trg_a` for one cycle; expect `pend_a`=0 and `a`=0.
- Glitch reject: pulse `key_b`=0 for 3 cycles, then 1. Expect `dcnt` restart, `pend_b` stays 0, and no event. A 4-cycle-stable press then gives `pend_b`=1.
- Saturation: give 4 clean presses on `c` with no grants. Expect `pend_c`=3 and `ovf`=3'b100. Raise `ovf_clr` together with a 5th press event; expect `ovf[2]`=1 (set wins). Raise `ovf_clr` alone; expect `ovf`=0.
- Simultaneous event and grant: with `pend_a`=1, align `trg_a`=1 with the `evt` cycle. Expect `pend_a`=1 unchanged. A stray `trg_b` with `pend_b`=0 leaves `pend_b` at 0.
- Reset mid-operation: with `pend_a`=2 and `dcnt_b` mid-count, assert `rst`=0 asynchronously between edges. Expect `a` and all `pend` at 0 immediately. After release, `key_b` still held gives `pend_b`=1 after 2+4 edges.
